// File: rtl/gift_pool_pkg.sv
// rtl/gift_pool_pkg.sv - shared gift kinds, screen geometry and LFSR step
package gift_pool_pkg;

  typedef enum logic [2:0] {
    KIND_INC = 3'd0,
    KIND_DEC = 3'd1,
    KIND_SPU = 3'd2,
    KIND_SPD = 3'd3,
    KIND_HID = 3'd4,
    KIND_SOT = 3'd5,
    KIND_DRP = 3'd6,
    KIND_MUL = 3'd7
  } gift_kind_e;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BOTTOM_Y = SCREEN_H;
  localparam int COORD_W  = $clog2(SCREEN_W);
  localparam int KIND_W   = 3;

  // Galois form of x^32 + x^22 + x^2 + x + 1, shifting right.
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_next(input logic [31:0] s);
    return {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/gift_pool_lfsr.sv
// rtl/gift_pool_lfsr.sv - free-running 32-bit Galois LFSR for spawn rolls and kinds
module gift_lfsr
  import gift_pool_pkg::*;
#(
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] lfsr
);

  always_ff @(posedge clock) begin
    if (reset) begin
      lfsr <= SEED;
    end else begin
      lfsr <= lfsr_next(lfsr);
    end
  end

endmodule

// File: rtl/gift_pool.sv
// rtl/gift_pool.sv - pool of falling gifts with spawn, fall, loss and paddle catch
module gift_pool
  import gift_pool_pkg::*;
#(
  parameter int          NSLOT    = 4,
  parameter int          CHANCE   = 8,
  parameter int          FALL_DIV = 2,
  parameter int          STEP     = 1,
  parameter int          BOTTOM   = BOTTOM_Y,
  parameter int          PADDLE_W = 64,
  parameter int          GIFT_H   = 8,
  parameter logic [31:0] SEED     = 32'hACE1_2468
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       spawn,
  input  logic [COORD_W-1:0]         in_x,
  input  logic [COORD_W-1:0]         in_y,
  input  logic                       tick,
  input  logic [COORD_W-1:0]         paddle_x,
  input  logic [COORD_W-1:0]         paddle_y,
  output logic [NSLOT-1:0]           active,
  output logic [COORD_W*NSLOT-1:0]   x_flat,
  output logic [COORD_W*NSLOT-1:0]   y_flat,
  output logic [KIND_W*NSLOT-1:0]    kind_flat,
  output logic                       caught,
  output logic [KIND_W-1:0]          caught_kind,
  output logic                       lost
);

  localparam int CNT_W = (FALL_DIV > 1) ? $clog2(FALL_DIV) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(FALL_DIV - 1);
  localparam logic [COORD_W:0]   STEP_X   = (COORD_W + 1)'(STEP);
  localparam logic [COORD_W:0]   BOTTOM_X = (COORD_W + 1)'(BOTTOM);
  localparam logic [COORD_W:0]   PW_X     = (COORD_W + 1)'(PADDLE_W);
  localparam logic [COORD_W:0]   GH_X     = (COORD_W + 1)'(GIFT_H);
  localparam logic [5:0]         CHANCE_X = 6'(CHANCE);

  logic [31:0]      lfsr;
  logic [4:0]       roll;
  logic             spawn_ok;
  logic [CNT_W-1:0] fall_cnt;
  logic             fall_wrap;
  logic [COORD_W:0] paddle_right;
  logic [NSLOT-1:0] free_vec;
  logic [NSLOT-1:0] alloc_sel;
  logic [NSLOT-1:0] catch_vec;
  logic [NSLOT-1:0] catch_sel;
  logic [NSLOT-1:0] lose_vec;
  gift_kind_e       sel_kind;
  logic             unused_lfsr_hi;

  gift_lfsr #(.SEED(SEED)) u_lfsr (
    .clock (clock),
    .reset (reset),
    .lfsr  (lfsr)
  );

  assign roll           = lfsr[4:0];
  assign unused_lfsr_hi = ^lfsr[31:5];
  assign spawn_ok       = spawn && ({1'b0, roll} < CHANCE_X);
  assign fall_wrap      = tick && (fall_cnt == CNT_LAST);
  assign paddle_right   = {1'b0, paddle_x} + PW_X;

  // Lowest set bit wins: v & -v isolates it.
  assign free_vec  = ~active;
  assign alloc_sel = free_vec & (~free_vec + 1'b1);
  assign catch_sel = catch_vec & (~catch_vec + 1'b1);

  always_ff @(posedge clock) begin
    if (reset) begin
      fall_cnt <= '0;
    end else if (tick) begin
      fall_cnt <= fall_wrap ? '0 : fall_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    logic               act_r;
    logic [COORD_W-1:0] x_r;
    logic [COORD_W-1:0] y_r;
    gift_kind_e         kind_r;
    logic [COORD_W:0]   y_next;

    assign y_next = {1'b0, y_r} + STEP_X;

    assign catch_vec[i] = act_r
                        && (x_r >= paddle_x)
                        && ({1'b0, x_r} < paddle_right)
                        && (({1'b0, y_r} + GH_X) >= {1'b0, paddle_y})
                        && (y_r <= paddle_y);

    assign lose_vec[i] = act_r && !catch_sel[i] && fall_wrap && (y_next >= BOTTOM_X);

    // Allocation only looks at slots already free at cycle start.
    always_ff @(posedge clock) begin
      if (reset) begin
        act_r  <= 1'b0;
        x_r    <= '0;
        y_r    <= '0;
        kind_r <= KIND_INC;
      end else if (catch_sel[i]) begin
        act_r <= 1'b0;
      end else if (act_r) begin
        if (fall_wrap) begin
          if (y_next >= BOTTOM_X) begin
            act_r <= 1'b0;
          end else begin
            y_r <= y_next[COORD_W-1:0];
          end
        end
      end else if (spawn_ok && alloc_sel[i]) begin
        act_r  <= 1'b1;
        x_r    <= in_x;
        y_r    <= in_y;
        kind_r <= gift_kind_e'(lfsr[2:0]);
      end
    end

    assign active[i]                         = act_r;
    assign x_flat[i*COORD_W +: COORD_W]      = x_r;
    assign y_flat[i*COORD_W +: COORD_W]      = y_r;
    assign kind_flat[i*KIND_W +: KIND_W]     = kind_r;
  end

  always_comb begin
    sel_kind = KIND_INC;
    for (int i = 0; i < NSLOT; i++) begin
      if (catch_sel[i]) begin
        sel_kind = gift_kind_e'(kind_flat[i*KIND_W +: KIND_W]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      caught      <= 1'b0;
      caught_kind <= '0;
      lost        <= 1'b0;
    end else begin
      caught <= |catch_vec;
      lost   <= |lose_vec;
      if (|catch_vec) begin
        caught_kind <= sel_kind;
      end
    end
  end

endmodule

// File: tb/tb_gift_pool.sv
// tb/tb_gift_pool.sv - randomized and directed checks of gift_pool against a behavioural model
module tb_gift_pool;

  localparam int          NSLOT    = 4;
  localparam int          CHANCE   = 8;
  localparam int          FALL_DIV = 2;
  localparam int          STEP     = 1;
  localparam int          BOTTOM   = 480;
  localparam int          PADDLE_W = 64;
  localparam int          GIFT_H   = 8;
  localparam logic [31:0] SEED     = 32'hACE1_2468;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic              spawn = 1'b0;
  logic              tick  = 1'b0;
  logic [9:0]        in_x = '0, in_y = '0;
  logic [9:0]        paddle_x = 10'd900, paddle_y = 10'd5;
  logic [NSLOT-1:0]  active;
  logic [10*NSLOT-1:0] x_flat, y_flat;
  logic [3*NSLOT-1:0]  kind_flat;
  logic              caught, lost;
  logic [2:0]        caught_kind;

  gift_pool dut (
    .clock       (clock),
    .reset       (reset),
    .spawn       (spawn),
    .in_x        (in_x),
    .in_y        (in_y),
    .tick        (tick),
    .paddle_x    (paddle_x),
    .paddle_y    (paddle_y),
    .active      (active),
    .x_flat      (x_flat),
    .y_flat      (y_flat),
    .kind_flat   (kind_flat),
    .caught      (caught),
    .caught_kind (caught_kind),
    .lost        (lost)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  bit          mact[NSLOT];
  int          mx[NSLOT], my[NSLOT], mk[NSLOT];
  int          mcnt = 0, mck = 0;
  bit          mcaught = 0, mlost = 0;
  logic [31:0] mlfsr = SEED;
  int          ci, fi, ny;
  bit          wrap;

  function automatic bit catchable(int i);
    int px = paddle_x;
    int py = paddle_y;
    return mact[i] && mx[i] >= px && mx[i] < px + PADDLE_W
           && my[i] >= py - GIFT_H && my[i] <= py;
  endfunction

  function automatic logic [NSLOT-1:0] model_active();
    logic [NSLOT-1:0] v;
    for (int i = 0; i < NSLOT; i++) v[i] = mact[i];
    return v;
  endfunction

  function automatic int model_roll();
    return int'(mlfsr % 32);
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NSLOT; i++) begin
        mact[i] = 0; mx[i] = 0; my[i] = 0; mk[i] = 0;
      end
      mcnt = 0; mck = 0; mcaught = 0; mlost = 0; mlfsr = SEED;
    end else begin
      ci = -1;
      fi = -1;
      for (int i = 0; i < NSLOT; i++) begin
        if (ci < 0 && catchable(i)) ci = i;
        if (fi < 0 && !mact[i]) fi = i;
      end
      wrap = tick && (mcnt == FALL_DIV - 1);
      if (tick) mcnt = wrap ? 0 : mcnt + 1;
      mlost = 0;
      for (int i = 0; i < NSLOT; i++) begin
        if (i == ci) begin
          mact[i] = 0;
        end else if (mact[i] && wrap) begin
          ny = my[i] + STEP;
          if (ny >= BOTTOM) begin
            mact[i] = 0;
            mlost = 1;
          end else begin
            my[i] = ny;
          end
        end
      end
      if (spawn && model_roll() < CHANCE && fi >= 0) begin
        mact[fi] = 1; mx[fi] = in_x; my[fi] = in_y; mk[fi] = int'(mlfsr % 8);
      end
      mcaught = (ci >= 0);
      if (ci >= 0) mck = mk[ci];
      mlfsr = mlfsr[0] ? ((mlfsr >> 1) ^ 32'h8020_0003) : (mlfsr >> 1);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("active", 32'(active), 32'(model_active()));
    for (int i = 0; i < NSLOT; i++) begin
      chk($sformatf("x%0d", i), 32'(x_flat[i*10 +: 10]), mx[i]);
      chk($sformatf("y%0d", i), 32'(y_flat[i*10 +: 10]), my[i]);
      chk($sformatf("kind%0d", i), 32'(kind_flat[i*3 +: 3]), mk[i]);
    end
    chk("caught", 32'(caught), 32'(mcaught));
    chk("lost", 32'(lost), 32'(mlost));
    chk("caught_kind", 32'(caught_kind), mck);
  endtask

  task automatic step();
    @(negedge clock);
    check_all();
  endtask

  task automatic spawn_roll(input int x, input int y, input int lo, input int hi);
    int n = 0;
    while (!(model_roll() >= lo && model_roll() <= hi) && n < 4000) begin
      step();
      n++;
    end
    if (n >= 4000) chk("roll_wait_timeout", 32'(n), 32'd0);
    in_x = 10'(x); in_y = 10'(y); spawn = 1'b1;
    step();
    spawn = 1'b0;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  int saved_kind;

  initial begin
    @(negedge clock);
    step();
    chk("reset_active", 32'(active), 32'd0);
    chk("reset_xflat", x_flat[31:0], 32'd0);
    reset = 1'b0;

    // Accepted roll then rejected roll at the threshold
    spawn_roll(100, 50, 3, 3);
    chk("spawn_active", 32'(active), 32'd1);
    chk("spawn_x", 32'(x_flat[9:0]), 32'd100);
    chk("spawn_y", 32'(y_flat[9:0]), 32'd50);
    chk("spawn_kind", 32'(kind_flat[2:0]), 32'd3);
    spawn_roll(300, 60, 8, 8);
    chk("roll8_ignored", 32'(active), 32'd1);

    // Fill the pool, then one more accepted roll with no free slot
    for (int k = 0; k < 3; k++) spawn_roll($urandom_range(0, 639), $urandom_range(50, 200), 0, CHANCE - 1);
    chk("pool_full", 32'(active), 32'hF);
    spawn_roll(7, 77, 0, CHANCE - 1);
    chk("fifth_ignored", 32'(active), 32'hF);

    // Fall timing and loss at the bottom
    do_reset();
    spawn_roll(30, 50, 0, CHANCE - 1);
    repeat (6) tick_pulse();
    chk("fall_y53", 32'(y_flat[9:0]), 32'd53);
    spawn_roll(40, 479, 0, CHANCE - 1);
    tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("lost_pulse", 32'(lost), 32'd1);
    chk("lost_active", 32'(active), 32'd1);
    chk("fall_y54", 32'(y_flat[9:0]), 32'd54);
    step();
    chk("lost_once", 32'(lost), 32'd0);

    // Catch window edges
    do_reset();
    spawn_roll(120, 440, 0, CHANCE - 1);
    saved_kind = mk[0];
    paddle_x = 10'd56; paddle_y = 10'd444;
    step();
    chk("miss_x_edge", 32'(caught), 32'd0);
    paddle_x = 10'd100; paddle_y = 10'd439;
    step();
    chk("miss_y_edge", 32'(caught), 32'd0);
    paddle_y = 10'd444;
    step();
    chk("catch_pulse", 32'(caught), 32'd1);
    chk("catch_kind", 32'(caught_kind), 32'(saved_kind));
    chk("catch_inactive", 32'(active), 32'd0);
    paddle_x = 10'd900; paddle_y = 10'd5;
    step();
    chk("catch_one_cycle", 32'(caught), 32'd0);
    chk("catch_kind_held", 32'(caught_kind), 32'(saved_kind));
    spawn_roll(120, 440, 0, CHANCE - 1);
    paddle_x = 10'd57; paddle_y = 10'd448;
    step();
    chk("catch_edges_hit", 32'(caught), 32'd1);
    paddle_x = 10'd900; paddle_y = 10'd5;

    // Two simultaneous catches resolve lowest first
    do_reset();
    spawn_roll(200, 300, 0, CHANCE - 1);
    spawn_roll(210, 300, 0, CHANCE - 1);
    paddle_x = 10'd190; paddle_y = 10'd300;
    step();
    chk("dual_first", 32'(active), 32'b0010);
    chk("dual_first_caught", 32'(caught), 32'd1);
    step();
    chk("dual_second", 32'(active), 32'd0);
    chk("dual_second_caught", 32'(caught), 32'd1);
    paddle_x = 10'd900; paddle_y = 10'd5;

    // Random traffic against the model
    for (int k = 0; k < 400; k++) begin
      spawn    = 1'($urandom % 2);
      tick     = 1'($urandom % 2);
      in_x     = 10'($urandom_range(0, 639));
      in_y     = 10'($urandom_range(380, 479));
      paddle_x = 10'($urandom_range(0, 600));
      paddle_y = 10'($urandom_range(400, 470));
      step();
    end
    spawn = 1'b0; tick = 1'b0;
    paddle_x = 10'd900; paddle_y = 10'd5;
    for (int k = 0; k < 3; k++) spawn_roll(k * 100, 400, 0, CHANCE - 1);
    tick = 1'b1; spawn = 1'b1;
    reset = 1'b1;
    step();
    reset = 1'b0; tick = 1'b0; spawn = 1'b0;
    chk("midfall_reset_active", 32'(active), 32'd0);
    chk("midfall_reset_y", y_flat[31:0], 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
